// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte-stream requesters.
// Grants whole bursts (ended by last, MAX_BURST rotation or HOLD_MAX stall) and sequences bytes start/done.
module uart_tx_arbiter #(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 16,
    parameter int HOLD_MAX  = 64
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [8*NREQ-1:0]    req_data_i,
    input  logic [NREQ-1:0]      req_last_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [NREQ-1:0]      grant_o,
    output logic                 tx_start_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_done_i,
    output logic                 busy_o
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [GW-1:0] LAST_G_RST = GW'(NREQ - 1);
    localparam logic [BW-1:0] BURST_END  = BW'(MAX_BURST - 1);
    localparam logic [HW-1:0] HOLD_END   = HW'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        START,
        WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [GW-1:0]     gidx_q, gidx_d;
    logic [GW-1:0]     last_g_q, last_g_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [7:0]        data_q, data_d;
    logic              last_q, last_d;

    logic              pick_found;
    logic [GW-1:0]     pick_idx;
    logic [GW-1:0]     cand;

    logic              sel_valid;
    logic              sel_last;
    logic [7:0]        sel_data;

    // Search starts just after the previous owner so it ends up with lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = GW'((int'(last_g_q) + i) % NREQ);
            if (!pick_found && req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gidx_q == GW'(k)) begin
                sel_valid = req_valid_i[k];
                sel_last  = req_last_i[k];
                sel_data  = req_data_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        last_g_d = last_g_q;
        burst_d  = burst_q;
        hold_d   = hold_q;
        data_d   = data_q;
        last_d   = last_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gidx_d           = pick_idx;
                    grant_d          = '0;
                    grant_d[pick_idx] = 1'b1;
                    burst_d          = '0;
                    hold_d           = '0;
                    state_d          = ACCEPT;
                end
            end
            ACCEPT: begin
                if (sel_valid) begin
                    data_d  = sel_data;
                    last_d  = sel_last;
                    hold_d  = '0;
                    state_d = START;
                end else if (hold_q == HOLD_END) begin
                    grant_d  = '0;
                    last_g_d = gidx_q;
                    state_d  = IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            START: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done_i) begin
                    if (last_q || (burst_q == BURST_END)) begin
                        grant_d  = '0;
                        last_g_d = gidx_q;
                        state_d  = IDLE;
                    end else begin
                        burst_d = burst_q + 1'b1;
                        state_d = ACCEPT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            last_g_q <= LAST_G_RST;
            burst_q  <= '0;
            hold_q   <= '0;
            data_q   <= 8'h00;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            last_g_q <= last_g_d;
            burst_q  <= burst_d;
            hold_q   <= hold_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end

    // Outputs decode registered state only; nothing flows combinationally from inputs.
    assign req_ready_o = (state_q == ACCEPT) ? grant_q : '0;
    assign grant_o     = grant_q;
    assign tx_start_o  = (state_q == START);
    assign tx_data_o   = data_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester/transmitter models plus an expected-byte scoreboard.
module tb_uart_tx_arbiter;

    localparam int NREQ      = 2;
    localparam int MAX_BURST = 16;
    localparam int HOLD_MAX  = 64;
    localparam int DONE_DLY  = 10;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [1:0]  req_valid_i = '0;
    logic [15:0] req_data_i = '0;
    logic [1:0]  req_last_i = '0;
    logic [1:0]  req_ready_o;
    logic [1:0]  grant_o;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic        tx_done_i = 1'b0;
    logic        busy_o;

    uart_tx_arbiter #(
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST),
        .HOLD_MAX  (HOLD_MAX)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .grant_o     (grant_o),
        .tx_start_o  (tx_start_o),
        .tx_data_o   (tx_data_o),
        .tx_done_i   (tx_done_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_starts = 0;
    int          last_start_cyc = 0;
    int          tx_timer = 0;
    int          start_log[$];
    logic [8:0]  rq0[$];
    logic [8:0]  rq1[$];
    logic [9:0]  exp_q[$];
    logic [9:0]  mon_e;
    logic [1:0]  fire;
    logic        st;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_drain(input int bound, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk_i);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Requester models: present queue head, pop on a valid&ready handshake.
    always @(posedge clk_i) begin
        fire = req_valid_i & req_ready_o;
        #1;
        if (fire[0] && rq0.size() > 0) void'(rq0.pop_front());
        if (fire[1] && rq1.size() > 0) void'(rq1.pop_front());
        req_valid_i[0] = (rq0.size() > 0);
        req_valid_i[1] = (rq1.size() > 0);
        if (rq0.size() > 0) {req_last_i[0], req_data_i[7:0]}  = rq0[0];
        if (rq1.size() > 0) {req_last_i[1], req_data_i[15:8]} = rq1[0];
    end

    // Transmitter model: done pulse a fixed number of cycles after each start.
    always @(posedge clk_i) begin
        st = tx_start_o;
        #1;
        tx_done_i = 1'b0;
        if (!reset_i) begin
            tx_timer = 0;
        end else if (st) begin
            tx_timer = DONE_DLY;
        end else if (tx_timer > 0) begin
            tx_timer--;
            if (tx_timer == 0) tx_done_i = 1'b1;
        end
    end

    always @(negedge clk_i) begin
        if (tx_start_o) begin
            n_starts++;
            last_start_cyc = cyc;
            start_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("start_with_empty_scoreboard", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("start_data", tx_data_o, mon_e[7:0]);
                chk("start_grant", grant_o, mon_e[9:8]);
            end
        end
    end

    initial begin
        int t0;
        int cnt01;
        int last01;
        int g10cyc;
        int n;
        int base;

        // Reset state
        reset_i = 1'b0;
        #100;
        chk("rst_grant", grant_o, 0);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_start", tx_start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_data", tx_data_o, 0);
        #100;
        @(negedge clk_i);
        reset_i = 1'b1;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            chk("idle_quiet", {grant_o, req_ready_o, tx_start_o, busy_o, tx_data_o}, 0);
        end

        // Two-byte burst from req0
        @(negedge clk_i);
        start_log.delete();
        t0 = cyc;
        exp_q.push_back({2'b01, 8'h48});
        exp_q.push_back({2'b01, 8'h69});
        rq0.push_back({1'b0, 8'h48});
        rq0.push_back({1'b1, 8'h69});
        wait_drain(300, "t2_drain");
        chk("t2_first_start_latency", start_log[0] - t0, 3);
        chk("t2_done_to_next_start", start_log[1] - start_log[0], DONE_DLY + 3);
        while (cyc < last_start_cyc + DONE_DLY + 1) @(negedge clk_i);
        chk("t2_busy_before_done", busy_o, 1);
        chk("t2_grant_held", grant_o, 2'b01);
        @(negedge clk_i);
        chk("t2_busy_after_done", busy_o, 0);
        chk("t2_grant_released", grant_o, 0);

        // Simultaneous single-byte bursts alternate after reset
        do_reset();
        @(negedge clk_i);
        exp_q.push_back({2'b01, 8'hA1});
        exp_q.push_back({2'b10, 8'hB2});
        exp_q.push_back({2'b01, 8'hA1});
        exp_q.push_back({2'b10, 8'hB2});
        rq0.push_back({1'b1, 8'hA1});
        rq0.push_back({1'b1, 8'hA1});
        rq1.push_back({1'b1, 8'hB2});
        rq1.push_back({1'b1, 8'hB2});
        wait_drain(500, "t3_drain");
        repeat (20) @(negedge clk_i);
        chk("t3_idle", busy_o, 0);

        // Forced rotation after MAX_BURST bytes
        @(negedge clk_i);
        for (int i = 0; i < MAX_BURST; i++) exp_q.push_back({2'b10, 8'(8'h10 + i)});
        for (int i = 0; i < 20; i++) rq1.push_back({1'b0, 8'(8'h10 + i)});
        n = 0;
        while (grant_o !== 2'b10 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("t4_req1_granted_first", grant_o, 2'b10);
        exp_q.push_back({2'b01, 8'hC0});
        for (int i = MAX_BURST; i < 20; i++) exp_q.push_back({2'b10, 8'(8'h10 + i)});
        rq0.push_back({1'b1, 8'hC0});
        wait_drain(1500, "t4_drain");
        repeat (90) @(negedge clk_i);
        chk("t4_revoked_idle", busy_o, 0);
        chk("t4_revoked_grant", grant_o, 0);

        // Stall mid-burst: hold timeout revokes req0, req1 follows
        @(negedge clk_i);
        exp_q.push_back({2'b01, 8'h5A});
        exp_q.push_back({2'b10, 8'h7E});
        rq0.push_back({1'b0, 8'h5A});
        rq1.push_back({1'b1, 8'h7E});
        cnt01 = 0;
        last01 = 0;
        g10cyc = -1;
        n = 0;
        while (g10cyc < 0 && n < 400) begin
            @(negedge clk_i);
            n++;
            if (req_ready_o == 2'b01) begin
                cnt01++;
                last01 = cyc;
            end
            if (grant_o == 2'b10) g10cyc = cyc;
        end
        chk("t5_ready_cycles", cnt01, HOLD_MAX + 1);
        chk("t5_regrant_gap", g10cyc - last01, 2);
        wait_drain(200, "t5_drain");
        repeat (20) @(negedge clk_i);
        chk("t5_idle", busy_o, 0);

        // Reset during WAIT_DONE, then arbitration restarts at req0
        @(negedge clk_i);
        exp_q.push_back({2'b01, 8'h33});
        rq0.push_back({1'b1, 8'h33});
        wait_drain(100, "t6_pre_drain");
        repeat (20) @(negedge clk_i);
        exp_q.push_back({2'b10, 8'h55});
        rq1.push_back({1'b1, 8'h55});
        wait_drain(100, "t6_55_start");
        repeat (3) @(negedge clk_i);
        chk("t6_pre_grant", grant_o, 2'b10);
        chk("t6_pre_busy", busy_o, 1);
        reset_i = 1'b0;
        #1;
        chk("t6_rst_grant", grant_o, 0);
        chk("t6_rst_ready", req_ready_o, 0);
        chk("t6_rst_start", tx_start_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        base = n_starts;
        repeat (30) @(negedge clk_i);
        chk("t6_no_spurious_start", n_starts, base);
        exp_q.push_back({2'b01, 8'h11});
        exp_q.push_back({2'b10, 8'h22});
        rq0.push_back({1'b1, 8'h11});
        rq1.push_back({1'b1, 8'h22});
        wait_drain(300, "t6_drain");
        repeat (20) @(negedge clk_i);
        chk("t6_idle", busy_o, 0);
        chk("req_queues_empty", rq0.size() + rq1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
